// File: rtl/mmio_periph_ctrl.sv
// Memory-mapped peripheral controller: reload timers, LED/switch/7-seg registers and a
// byte-level UART interface with TX/RX FIFOs, behind a relocatable address window.
module mmio_periph_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned SW_W       = 8,
    parameter int unsigned DIGI_W     = 12
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [DIGI_W-1:0] digi,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              irqout,
    input  logic              PC_31
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = AW + 1;
    localparam logic [31:0] MiscAddr  = BASE_ADDR + 32'h100;
    localparam logic [31:0] TimerSpan = 32'(16 * NUM_TIMERS);
    localparam logic [CW-1:0] Depth   = CW'(FIFO_DEPTH);

    localparam logic [2:0] RegLed   = 3'd0;
    localparam logic [2:0] RegSw    = 3'd1;
    localparam logic [2:0] RegDigi  = 3'd2;
    localparam logic [2:0] RegTxd   = 3'd3;
    localparam logic [2:0] RegRxd   = 3'd4;
    localparam logic [2:0] RegStat  = 3'd5;
    localparam logic [2:0] RegIrqen = 3'd6;

    // Address decode
    logic [31:0] toff, moff;
    logic        t_hit, m_hit;
    logic [1:0]  t_reg;
    logic [2:0]  m_reg;
    logic        m_wr, m_rd;

    assign toff  = addr - BASE_ADDR;
    assign moff  = addr - MiscAddr;
    assign t_hit = (toff < TimerSpan) && (toff[3:2] != 2'd3) && (toff[1:0] == 2'd0);
    assign m_hit = (moff[31:5] == 27'd0) && (moff[1:0] == 2'd0) && (moff[4:2] != 3'd7);
    assign t_reg = toff[3:2];
    assign m_reg = moff[4:2];
    assign m_wr  = wr && m_hit;
    assign m_rd  = rd && m_hit;

    // Timers
    logic [31:0]           th_q   [NUM_TIMERS];
    logic [31:0]           th_d   [NUM_TIMERS];
    logic [31:0]           tl_q   [NUM_TIMERS];
    logic [31:0]           tl_d   [NUM_TIMERS];
    logic [2:0]            tcon_q [NUM_TIMERS];
    logic [2:0]            tcon_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] t_sel;
    logic [NUM_TIMERS-1:0] t_irq;

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            t_sel[i]  = t_hit && (toff[6:4] == 3'(i));
            th_d[i]   = th_q[i];
            tl_d[i]   = tl_q[i];
            tcon_d[i] = tcon_q[i];
            if (tcon_q[i][0]) begin
                if (tl_q[i] == 32'hFFFF_FFFF) begin
                    tl_d[i] = th_q[i];
                    if (tcon_q[i][1]) tcon_d[i][2] = 1'b1;
                end else begin
                    tl_d[i] = tl_q[i] + 32'd1;
                end
            end
            // CPU writes override the count/reload update; status can only be cleared
            if (wr && t_sel[i]) begin
                case (t_reg)
                    2'd0:    th_d[i]   = wdata;
                    2'd1:    tl_d[i]   = wdata;
                    2'd2:    tcon_d[i] = {tcon_q[i][2] & wdata[2], wdata[1:0]};
                    default: ;
                endcase
            end
            t_irq[i] = tcon_q[i][2];
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                th_q[i]   <= '0;
                tl_q[i]   <= '0;
                tcon_q[i] <= '0;
            end
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Simple registers
    logic [LED_W-1:0]  led_q;
    logic [DIGI_W-1:0] digi_q;
    logic [1:0]        irqen_q;
    logic              stat_wr;

    assign stat_wr = m_wr && (m_reg == RegStat);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            digi_q  <= '0;
            irqen_q <= '0;
        end else if (m_wr) begin
            if (m_reg == RegLed)   led_q   <= wdata[LED_W-1:0];
            if (m_reg == RegDigi)  digi_q  <= wdata[DIGI_W-1:0];
            if (m_reg == RegIrqen) irqen_q <= wdata[1:0];
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

    // TX FIFO and drain
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_ovf_q, tx_start_q;
    logic          tx_full, tx_empty, tx_idle, tx_wr_req, tx_push;

    assign tx_full   = (tx_cnt_q == Depth);
    assign tx_empty  = (tx_cnt_q == '0);
    // One-cycle hold-off after each pulse covers the sender's busy latency
    assign tx_idle   = ~tx_busy & ~tx_start_q;
    assign tx_start  = ~tx_empty & tx_idle;
    assign tx_data   = tx_mem[tx_rp_q];
    assign tx_wr_req = m_wr && (m_reg == RegTxd);
    assign tx_push   = tx_wr_req && (~tx_full || tx_start);

    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= tx_start;
            if (tx_push)  tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_start) tx_rp_q <= tx_rp_q + AW'(1);
            case ({tx_push, tx_start})
                2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
                default: ;
            endcase
            tx_ovf_q <= (tx_ovf_q & ~(stat_wr & wdata[4])) | (tx_wr_req & ~tx_push);
        end
    end

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q;
    logic          rx_ovf_q;
    logic          rx_full, rx_empty, rx_pop, rx_push;

    assign rx_full  = (rx_cnt_q == Depth);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = m_rd && (m_reg == RegRxd) && ~rx_empty;
    assign rx_push  = rx_valid && (~rx_full || rx_pop);

    always_ff @(posedge sysclk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
                default: ;
            endcase
            rx_ovf_q <= (rx_ovf_q & ~(stat_wr & wdata[5])) | (rx_valid & ~rx_push);
        end
    end

    // Read mux and interrupt
    logic [31:0] stat;

    assign stat = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 1'b0, tx_busy, rx_ovf_q, tx_ovf_q,
                   rx_full, ~rx_empty, tx_empty, tx_full};

    always_comb begin
        rdata = '0;
        if (rd) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (t_sel[i]) begin
                    case (t_reg)
                        2'd0:    rdata = th_q[i];
                        2'd1:    rdata = tl_q[i];
                        2'd2:    rdata = {29'd0, tcon_q[i]};
                        default: rdata = '0;
                    endcase
                end
            end
            if (m_hit) begin
                case (m_reg)
                    RegLed:   rdata = 32'(led_q);
                    RegSw:    rdata = 32'(switch);
                    RegDigi:  rdata = 32'(digi_q);
                    RegRxd:   rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp_q]};
                    RegStat:  rdata = stat;
                    RegIrqen: rdata = {30'd0, irqen_q};
                    default:  rdata = '0;
                endcase
            end
        end
    end

    assign irqout = ~PC_31 & ((|t_irq) | (irqen_q[0] & ~rx_empty) |
                              (irqen_q[1] & tx_empty & tx_idle));

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Self-checking bench for mmio_periph_ctrl: register vector table, scoreboarded UART
// queues, and hand sequences for timer reload, FIFO corner cases and async reset.
module tb_mmio_periph_ctrl;

    localparam logic [31:0] B = 32'h4000_0000;
    localparam logic [31:0] M = B + 32'h100;

    logic        sysclk = 1'b0;
    logic        reset, rd, wr, tx_busy, rx_valid, PC_31;
    logic [31:0] addr, wdata, rdata, rdata2;
    logic [7:0]  led, led2, switch, tx_data, tx_data2, rx_data;
    logic [11:0] digi, digi2;
    logic        tx_start, tx_start2, irqout, irqout2;

    int nchk = 0;
    int nerr = 0;
    int cyc_n = 0;
    int last_start = -100;
    logic [31:0] rd2_last;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];

    mmio_periph_ctrl dut (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .switch(switch), .digi(digi), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .irqout(irqout), .PC_31(PC_31)
    );

    mmio_periph_ctrl #(.BASE_ADDR(32'h8000_0000), .NUM_TIMERS(4)) dut2 (
        .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .led(led2), .switch(switch), .digi(digi2), .tx_data(tx_data2),
        .tx_start(tx_start2), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .irqout(irqout2), .PC_31(PC_31)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // TX scoreboard: every pulse must match the queue head and respect the 2-cycle spacing
    always @(negedge sysclk) begin
        if (!reset && tx_start) begin
            if (txq.size() == 0) begin
                chk("tx_unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
            end
            chk("tx_spacing_ok", 32'(cyc_n - last_start >= 2), 32'd1);
            last_start = cyc_n;
        end
    end

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; rd = 1'b1;
        #1;
        v = rdata;
        rd2_last = rdata2;
        cyc();
        rd = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input bit keep);
        rx_data = d; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        if (keep) rxq.push_back(d);
    endtask

    task automatic rx_read_chk(input string name);
        logic [31:0] v;
        bus_rd(M + 32'h10, v);
        if (rxq.size() == 0) chk({name, "_queue_empty"}, v, 32'hFFFF_FFFF);
        else chk(name, v, 32'(rxq.pop_front()));
    endtask

    typedef struct {
        logic        wr;
        logic        on2;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        logic [31:0] v;
        vecs = '{
            '{1'b0, 1'b0, M,              32'h0,         32'h0,         "rst_led"},
            '{1'b0, 1'b0, B + 32'h8,      32'h0,         32'h0,         "rst_tcon0"},
            '{1'b0, 1'b0, M + 32'h14,     32'h0,         32'h2,         "rst_stat"},
            '{1'b0, 1'b0, M + 32'h18,     32'h0,         32'h0,         "rst_irqen"},
            '{1'b1, 1'b0, M,              32'h1A5,       32'h0,         ""},
            '{1'b0, 1'b0, M,              32'h0,         32'hA5,        "led_rw"},
            '{1'b0, 1'b0, M + 32'h4,      32'h0,         32'h3C,        "switch_ro"},
            '{1'b1, 1'b0, M + 32'h8,      32'hFFF123,    32'h0,         ""},
            '{1'b0, 1'b0, M + 32'h8,      32'h0,         32'h123,       "digi_rw"},
            '{1'b1, 1'b0, B,              32'hDEADBEEF,  32'h0,         ""},
            '{1'b0, 1'b0, B,              32'h0,         32'hDEADBEEF,  "th0_rw"},
            '{1'b0, 1'b0, M + 32'hC,      32'h0,         32'h0,         "txd_reads_0"},
            '{1'b0, 1'b0, M + 32'h1C,     32'h0,         32'h0,         "unmapped_misc"},
            '{1'b0, 1'b0, B + 32'hC,      32'h0,         32'h0,         "unmapped_t0c"},
            '{1'b1, 1'b0, B + 32'h20,     32'h55,        32'h0,         ""},
            '{1'b0, 1'b0, B + 32'h20,     32'h0,         32'h0,         "no_timer2"},
            '{1'b1, 1'b0, M + 32'h18,     32'hFFFFFFFF,  32'h0,         ""},
            '{1'b0, 1'b0, M + 32'h18,     32'h0,         32'h3,         "irqen_rw"},
            '{1'b1, 1'b0, M + 32'h18,     32'h0,         32'h0,         ""},
            '{1'b1, 1'b0, 32'h8000_0038,  32'h2,         32'h0,         ""},
            '{1'b0, 1'b1, 32'h8000_0038,  32'h0,         32'h2,         "p2_t3_tcon"},
            '{1'b0, 1'b1, 32'h4000_0008,  32'h0,         32'h0,         "p2_old_base"}
        };

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0; PC_31 = 1'b0; switch = 8'h3C;
        #12 reset = 1'b0;
        cyc();
        chk("rst_irqout", 32'(irqout), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                bus_wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_rd(vecs[i].addr, v);
                chk(vecs[i].name, vecs[i].on2 ? rd2_last : v, vecs[i].exp);
            end
        end
        chk("led_port", 32'(led), 32'hA5);
        addr = M; #1;
        chk("rdata_idle_0", rdata, 32'd0);

        // Timer 1 reload and interrupt
        bus_wr(B + 32'h10, 32'hFFFF_FFFD);
        bus_wr(B + 32'h14, 32'hFFFF_FFFE);
        bus_wr(B + 32'h18, 32'h3);
        cyc();
        bus_rd(B + 32'h14, v); chk("t1_tl_max", v, 32'hFFFF_FFFF);
        bus_rd(B + 32'h14, v); chk("t1_tl_reload", v, 32'hFFFF_FFFD);
        bus_rd(B + 32'h18, v); chk("t1_tcon_irq", v, 32'h7);
        chk("irq_user", 32'(irqout), 32'd1);
        PC_31 = 1'b1; #1;
        chk("irq_kernel_mask", 32'(irqout), 32'd0);
        PC_31 = 1'b0;
        bus_wr(B + 32'h18, 32'h3);
        chk("irq_cleared", 32'(irqout), 32'd0);
        bus_rd(B + 32'h18, v); chk("t1_tcon_clr", v, 32'h3);
        bus_wr(B + 32'h18, 32'h0);

        // TL write coinciding with rollover
        bus_wr(B + 32'h4, 32'hFFFF_FFFE);
        bus_wr(B + 32'h8, 32'h1);
        cyc();
        bus_wr(B + 32'h4, 32'h1234);
        bus_rd(B + 32'h4, v); chk("tl_write_wins", v, 32'h1234);
        bus_wr(B + 32'h8, 32'h0);

        // TX queue fill, overflow, drain
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_wr(M + 32'hC, 32'h41 + 32'(i));
            txq.push_back(8'(8'h41 + i));
        end
        bus_rd(M + 32'h14, v); chk("tx_full_stat", v, 32'h0000_0841);
        bus_wr(M + 32'hC, 32'h49);
        bus_rd(M + 32'h14, v); chk("tx_ovf_stat", v, 32'h0000_0851);
        tx_busy = 1'b0;
        for (int i = 0; i < 60 && txq.size() != 0; i++) cyc();
        chk("tx_drained", 32'(txq.size()), 32'd0);
        cyc();
        bus_rd(M + 32'h14, v); chk("tx_empty_ovf", v, 32'h0000_0012);
        bus_wr(M + 32'h14, 32'h10);
        bus_rd(M + 32'h14, v); chk("tx_ovf_w1c", v, 32'h0000_0002);

        // TX-drained interrupt and single-byte latency
        bus_wr(M + 32'h18, 32'h2);
        chk("irq_tx_idle", 32'(irqout), 32'd1);
        txq.push_back(8'h77);
        bus_wr(M + 32'hC, 32'h77);
        chk("tx_start_latency", 32'(tx_start), 32'd1);
        chk("tx_data_latency", 32'(tx_data), 32'h77);
        chk("irq_tx_busy", 32'(irqout), 32'd0);
        cyc();
        bus_wr(M + 32'h18, 32'h0);

        // RX queue
        rx_pulse(8'h55, 1'b1);
        rx_pulse(8'hAA, 1'b1);
        bus_rd(M + 32'h14, v); chk("rx_cnt2", v, 32'h0002_0006);
        bus_wr(M + 32'h18, 32'h1);
        chk("irq_rx", 32'(irqout), 32'd1);
        rx_read_chk("rx_first");
        rx_read_chk("rx_second");
        chk("irq_rx_off", 32'(irqout), 32'd0);
        bus_rd(M + 32'h10, v); chk("rx_empty_read", v, 32'd0);
        bus_rd(M + 32'h14, v); chk("rx_cnt0", v, 32'h0000_0002);
        bus_wr(M + 32'h18, 32'h0);

        // RX full with simultaneous push/pop, then overflow
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h60 + i), 1'b1);
        bus_rd(M + 32'h14, v); chk("rx_full_stat", v, 32'h0008_000E);
        rx_data = 8'h68; rx_valid = 1'b1;
        addr = M + 32'h10; rd = 1'b1; #1;
        chk("rx_simul_head", rdata, 32'(rxq.pop_front()));
        cyc();
        rd = 1'b0; rx_valid = 1'b0;
        rxq.push_back(8'h68);
        bus_rd(M + 32'h14, v); chk("rx_simul_stat", v, 32'h0008_000E);
        rx_pulse(8'h69, 1'b0);
        bus_rd(M + 32'h14, v); chk("rx_ovf_stat", v, 32'h0008_002E);
        for (int i = 0; i < 8; i++) rx_read_chk("rx_drain");
        bus_wr(M + 32'h14, 32'h20);
        bus_rd(M + 32'h14, v); chk("rx_ovf_w1c", v, 32'h0000_0002);

        // Asynchronous reset mid-count with an interrupt pending
        bus_wr(B + 32'h4, 32'hFFFF_FFFF);
        bus_wr(B + 32'h8, 32'h3);
        cyc();
        chk("pre_rst_irq", 32'(irqout), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_irqout", 32'(irqout), 32'd0);
        chk("arst_tx_start", 32'(tx_start), 32'd0);
        chk("arst_led", 32'(led), 32'd0);
        addr = B + 32'h8; rd = 1'b1; #1;
        chk("arst_tcon0", rdata, 32'd0);
        addr = M; #1;
        chk("arst_led_rd", rdata, 32'd0);
        rd = 1'b0;
        #2 reset = 1'b0;
        cyc();
        bus_rd(B + 32'h4, v); chk("post_rst_tl0", v, 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
